// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM that sequences the datapath control signals of a
//            multicycle MIPS-style processor. Optional JUMP state is enabled
//            by defining MULTICYCLE_JUMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;
    localparam logic [1:0] c_ALU_FUNC = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8
`ifdef MULTICYCLE_JUMP_EN
       ,S_JUMP     = 4'd9
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    // Opcode is consulted only in DECODE and MEMADDR; every other state has a
    // fixed successor, and unused encodings recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: state_d = S_MEMADDR;
                    c_OP_RTYPE:       state_d = S_EXECUTE;
                    c_OP_BEQ:         state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    c_OP_J:           state_d = S_JUMP;
`endif
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: state_d = (opcode == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_RWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = c_ALU_ADD;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_ALU_FUNC;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = c_ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for multicycle_control; expected
//            state walks and control words are hand-written constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst,PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0]}
    logic [15:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                   IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

    logic [15:0] ctrl_tbl [10] = '{
        16'b1001001000_000100,  // 0 FETCH
        16'b0000000000_001100,  // 1 DECODE
        16'b0000000100_001000,  // 2 MEMADDR
        16'b0011000000_000000,  // 3 MEMREAD
        16'b0000010010_000000,  // 4 MEMWB
        16'b0010100000_000000,  // 5 MEMWRITE
        16'b0000000100_000010,  // 6 EXECUTE
        16'b0000000011_000000,  // 7 RWB
        16'b0100000100_010001,  // 8 BRANCH
        16'b1000000000_100000   // 9 JUMP
    };

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b100011;
        #2;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold_state: got %0d expected 0", state);
        end
        n_checks++;
        if (ctrl !== ctrl_tbl[0]) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", ctrl, ctrl_tbl[0]);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [6];
        exp_s  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_s [5];
        exp_s  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL sw_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
        end
    endtask

    // Opcode switches to lw while in EXECUTE; the R-type walk must not change.
    task automatic test_rtype();
        logic [3:0] exp_s [5];
        exp_s  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL rtype_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
            if (i == 2) opcode = 6'b100011;
        end
    endtask

    task automatic test_beq();
        logic [3:0] exp_s [4];
        exp_s  = '{4'd0, 4'd1, 4'd8, 4'd0};
        opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL beq_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL beq_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
        end
    endtask

    task automatic test_jump();
`ifdef MULTICYCLE_JUMP_EN
        localparam int N = 4;
        logic [3:0] exp_s [N];
        exp_s = '{4'd0, 4'd1, 4'd9, 4'd0};
`else
        localparam int N = 3;
        logic [3:0] exp_s [N];
        exp_s = '{4'd0, 4'd1, 4'd0};
`endif
        opcode = 6'b000010;
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL jump_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL jump_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
        end
    endtask

    task automatic test_unknown();
        logic [3:0] exp_s [3];
        exp_s  = '{4'd0, 4'd1, 4'd0};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL unknown_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
            n_checks++;
            if (ctrl !== ctrl_tbl[exp_s[i]]) begin
                n_fail++;
                $display("FAIL unknown_ctrl[%0d]: got %b expected %b", i, ctrl, ctrl_tbl[exp_s[i]]);
            end
        end
    endtask

    // Reset lands between edges while in MEMREAD; then the lw walk restarts.
    task automatic test_reset_mid();
        logic [3:0] exp_s [6];
        opcode = 6'b100011;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 4'd3) begin
            n_fail++;
            $display("FAIL mid_pre_state: got %0d expected 3", state);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_async_state: got %0d expected 0", state);
        end
        n_checks++;
        if (ctrl !== ctrl_tbl[0]) begin
            n_fail++;
            $display("FAIL mid_async_ctrl: got %b expected %b", ctrl, ctrl_tbl[0]);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_hold_state: got %0d expected 0", state);
        end
        reset = 1'b0;
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (state !== exp_s[i]) begin
                n_fail++;
                $display("FAIL mid_after_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 6'b000000;
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_jump();
        test_unknown();
        test_reset_mid();
        test_sw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
